// File: rtl/vdot_pkg.sv
// Shared definitions for the FP16 dot-product issue controller.
// Contents: vector/lane geometry, FP16 reference constants and the
// controller FSM state encoding.
package vdot_pkg;

   localparam int VEC_W  = 256;   // one operand vector: 16 lanes x 16 bits
   localparam int LANE_W = 16;    // FP16 lane width, also the result width
   localparam int LANES  = 16;

   localparam logic [LANE_W-1:0] FP16_ONE = 16'h3c00;
   localparam logic [LANE_W-1:0] FP16_MAX = 16'h7bff;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/vdot_issue_ctrl_if.sv
// Host-side request/response bundle of the dot-product issue controller.
// Request channel : req_valid/req_ready handshake carrying req_a, req_b
//                   (16 FP16 lanes each) and req_tag.
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_data,
//                   rsp_ovf, rsp_timeout and rsp_tag.
// master = host side, slave = controller side.
interface vdot_issue_ctrl_if #(parameter int TAG_W = 4);
   import vdot_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [VEC_W-1:0]  req_a;
   logic [VEC_W-1:0]  req_b;
   logic [TAG_W-1:0]  req_tag;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [LANE_W-1:0] rsp_data;
   logic              rsp_ovf;
   logic              rsp_timeout;
   logic [TAG_W-1:0]  rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_timeout, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_timeout, rsp_tag
   );

endinterface

// File: rtl/vdot_req_fifo.sv
// Two-entry synchronous FIFO used to buffer operand requests.
// Ports: clk, rst (sync, active high); push/push_data write side;
//        pop read side with head = oldest entry (valid while !empty);
//        count (0..2), full, empty derived from the registered count.
// Push while full and pop while empty are ignored; push and pop in the
// same cycle are allowed.
module vdot_req_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign count   = count_q;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count/pointers alone define which slots are live.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
         if (push_ok && (wr_ptr_q == 1'(gi))) mem_q[gi] <= push_data;
      end
   end

endmodule

// File: rtl/vdot_issue_ctrl.sv
// Issue controller for the pipelined 16-lane FP16 dot-product unit.
// Ports: clk, rst (sync, active high)
//        host      : request/response bundle (slave side)
//        dot_a/b   : operands held stable for the whole operation
//        dot_start : registered start, high from issue until done/abort
//        dot_done, dot_out, dot_V : completion, result, overflow from unit
//        busy      : request buffered or operation in flight
//        ovf_count : saturating count of accepted responses with rsp_ovf=1
// TIMEOUT must exceed the unit's 6-cycle latency or every op aborts.
module vdot_issue_ctrl
   import vdot_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   vdot_issue_ctrl_if.slave  host,
   output logic [VEC_W-1:0]  dot_a,
   output logic [VEC_W-1:0]  dot_b,
   output logic              dot_start,
   input  logic              dot_done,
   input  logic [LANE_W-1:0] dot_out,
   input  logic              dot_V,
   output logic              busy,
   output logic [CNT_W-1:0]  ovf_count
);

   localparam int ENTRY_W = 2 * VEC_W + TAG_W;
   localparam int WD_W    = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [VEC_W-1:0]  dot_a_q, dot_a_d;
   logic [VEC_W-1:0]  dot_b_q, dot_b_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              dot_start_q, dot_start_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [LANE_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_ovf_q, rsp_ovf_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

   logic [ENTRY_W-1:0] fifo_head;
   logic [1:0]         fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               wd_expired;
   logic               rsp_fire;

   assign fifo_push  = host.req_valid & ~fifo_full;
   assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
   assign rsp_fire   = (state_q == ST_RESP) & host.rsp_ready;

   vdot_req_fifo #(.WIDTH(ENTRY_W)) u_req_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({host.req_a, host.req_b, host.req_tag}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; done beats a simultaneous watchdog expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty)             state_d = ST_RUN;
         ST_RUN:  if (dot_done || wd_expired)  state_d = ST_RESP;
         ST_RESP: if (host.rsp_ready)          state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   // Datapath next values driven by the FSM
   always_comb begin
      dot_a_d       = dot_a_q;
      dot_b_d       = dot_b_q;
      tag_d         = tag_q;
      dot_start_d   = dot_start_q;
      wd_d          = wd_q;
      rsp_data_d    = rsp_data_q;
      rsp_ovf_d     = rsp_ovf_q;
      rsp_timeout_d = rsp_timeout_q;
      ovf_count_d   = ovf_count_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               dot_a_d     = fifo_head[ENTRY_W-1 -: VEC_W];
               dot_b_d     = fifo_head[TAG_W +: VEC_W];
               tag_d       = fifo_head[TAG_W-1:0];
               dot_start_d = 1'b1;
               wd_d        = '0;
            end
         end
         ST_RUN: begin
            wd_d = wd_q + WD_W'(1);
            if (dot_done) begin
               rsp_data_d    = dot_out;
               rsp_ovf_d     = dot_V;
               rsp_timeout_d = 1'b0;
               dot_start_d   = 1'b0;
            end else if (wd_expired) begin
               rsp_data_d    = '0;
               rsp_ovf_d     = 1'b0;
               rsp_timeout_d = 1'b1;
               dot_start_d   = 1'b0;
            end
         end
         ST_RESP: begin
            if (rsp_fire && rsp_ovf_q && (ovf_count_q != {CNT_W{1'b1}}))
               ovf_count_d = ovf_count_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dot_a_q       <= '0;
         dot_b_q       <= '0;
         tag_q         <= '0;
         dot_start_q   <= 1'b0;
         wd_q          <= '0;
         rsp_data_q    <= '0;
         rsp_ovf_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         ovf_count_q   <= '0;
      end else begin
         dot_a_q       <= dot_a_d;
         dot_b_q       <= dot_b_d;
         tag_q         <= tag_d;
         dot_start_q   <= dot_start_d;
         wd_q          <= wd_d;
         rsp_data_q    <= rsp_data_d;
         rsp_ovf_q     <= rsp_ovf_d;
         rsp_timeout_q <= rsp_timeout_d;
         ovf_count_q   <= ovf_count_d;
      end
   end

   // Outputs
   always_comb begin
      host.req_ready   = ~fifo_full;
      host.rsp_valid   = (state_q == ST_RESP);
      host.rsp_data    = rsp_data_q;
      host.rsp_ovf     = rsp_ovf_q;
      host.rsp_timeout = rsp_timeout_q;
      host.rsp_tag     = tag_q;
      dot_a            = dot_a_q;
      dot_b            = dot_b_q;
      dot_start        = dot_start_q;
      busy             = (fifo_count != 2'd0) || (state_q != ST_IDLE);
      ovf_count        = ovf_count_q;
   end

endmodule

// File: tb/tb_vdot_issue_ctrl.sv
// Directed bench for vdot_issue_ctrl with a behavioural dot-unit stub:
// done rises 6 cycles after start and stays up while start is high;
// the result is a table of hand-computed dot products of uniform vectors.
module tb_vdot_issue_ctrl;
   import vdot_pkg::*;

   localparam int TAG_W   = 4;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [VEC_W-1:0]  dot_a, dot_b;
   logic              dot_start;
   logic              dot_done;
   logic [LANE_W-1:0] dot_out;
   logic              dot_V;
   logic              busy;
   logic [CNT_W-1:0]  ovf_count;

   always #5 clk = ~clk;

   vdot_issue_ctrl_if #(.TAG_W(TAG_W)) host();

   vdot_issue_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (host),
      .dot_a     (dot_a),
      .dot_b     (dot_b),
      .dot_start (dot_start),
      .dot_done  (dot_done),
      .dot_out   (dot_out),
      .dot_V     (dot_V),
      .busy      (busy),
      .ovf_count (ovf_count)
   );

   // Dot unit stub
   int   stub_cnt;
   logic stub_hang;

   always_ff @(posedge clk) begin
      if (rst || !dot_start) stub_cnt <= 0;
      else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
   end

   always_comb begin
      dot_done = dot_start && (stub_cnt >= 6) && !stub_hang;
      dot_out  = 16'h0000;
      dot_V    = 1'b0;
      if (dot_a[15:0] == FP16_ONE && dot_b[15:0] == FP16_ONE)
         dot_out = 16'h4c00;                        // 16 * 1.0 = 16.0
      else if (dot_a[15:0] == FP16_ONE && dot_b[15:0] == 16'h4000)
         dot_out = 16'h5000;                        // 16 * 2.0 = 32.0
      else if (dot_a[15:0] == FP16_MAX && dot_b[15:0] == FP16_MAX) begin
         dot_out = 16'h7c00;                        // overflows to +inf
         dot_V   = 1'b1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0]      r_data;
   logic             r_ovf, r_to;
   logic [TAG_W-1:0] r_tag;

   function automatic logic [VEC_W-1:0] rep(input logic [15:0] v);
      return {LANES{v}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                           input logic [TAG_W-1:0] tag);
      int g;
      g = 0;
      host.req_valid = 1'b1;
      host.req_a     = a;
      host.req_b     = b;
      host.req_tag   = tag;
      while (!host.req_ready && g < 200) begin
         step();
         g++;
      end
      if (!host.req_ready) chk("push_ready", 32'(host.req_ready), 32'd1);
      step();
      host.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int limit);
      int n;
      n = 0;
      while (!host.rsp_valid && n < limit) begin
         step();
         n++;
      end
      if (!host.rsp_valid) chk({tag, "_rsp_valid"}, 32'(host.rsp_valid), 32'd1);
   endtask

   // Push one request, wait for its response and accept it (rsp_ready=1).
   task automatic run_op(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                         input logic [TAG_W-1:0] tag);
      push_req(a, b, tag);
      wait_rsp("op", 40);
      r_data = host.rsp_data;
      r_ovf  = host.rsp_ovf;
      r_to   = host.rsp_timeout;
      r_tag  = host.rsp_tag;
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=still_running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int t0, nrsp, low_run, min_gap, hi, pushes;
      logic seen_high, stable, saw_rsp;
      logic [15:0] d [3];
      logic [TAG_W-1:0] tg [3];
      int rc [3];

      rst            = 1'b1;
      stub_hang      = 1'b0;
      host.req_valid = 1'b0;
      host.req_a     = '0;
      host.req_b     = '0;
      host.req_tag   = '0;
      host.rsp_ready = 1'b0;
      repeat (3) step();

      // Reset values
      chk("rst_req_ready",   32'(host.req_ready),   32'd1);
      chk("rst_rsp_valid",   32'(host.rsp_valid),   32'd0);
      chk("rst_dot_start",   32'(dot_start),        32'd0);
      chk("rst_busy",        32'(busy),             32'd0);
      chk("rst_ovf_count",   32'(ovf_count),        32'd0);
      chk("rst_rsp_data",    32'(host.rsp_data),    32'd0);
      chk("rst_rsp_tag",     32'(host.rsp_tag),     32'd0);
      chk("rst_rsp_ovf",     32'(host.rsp_ovf),     32'd0);
      chk("rst_rsp_timeout", 32'(host.rsp_timeout), 32'd0);
      chk("rst_dot_a_zero",  32'(dot_a == '0 && dot_b == '0), 32'd1);
      rst = 1'b0;
      step();

      // Unloaded latency: handshake at cycle 0
      host.rsp_ready = 1'b1;
      host.req_valid = 1'b1;
      host.req_a     = rep(FP16_ONE);
      host.req_b     = rep(FP16_ONE);
      host.req_tag   = 4'd3;
      chk("lat_c0_ready", 32'(host.req_ready), 32'd1);
      step();
      host.req_valid = 1'b0;
      chk("lat_c1_start", 32'(dot_start), 32'd0);
      chk("lat_c1_busy",  32'(busy),      32'd1);
      step();
      chk("lat_c2_start", 32'(dot_start), 32'd1);
      chk("lat_c2_dot_a", 32'(dot_a == rep(FP16_ONE) && dot_b == rep(FP16_ONE)), 32'd1);
      repeat (6) step();
      chk("lat_c8_done",  32'(dot_done),       32'd1);
      chk("lat_c8_valid", 32'(host.rsp_valid), 32'd0);
      step();
      chk("lat_c9_valid", 32'(host.rsp_valid),   32'd1);
      chk("lat_c9_data",  32'(host.rsp_data),    32'h4c00);
      chk("lat_c9_ovf",   32'(host.rsp_ovf),     32'd0);
      chk("lat_c9_to",    32'(host.rsp_timeout), 32'd0);
      chk("lat_c9_tag",   32'(host.rsp_tag),     32'd3);
      chk("lat_c9_start", 32'(dot_start),        32'd0);
      step();
      chk("lat_c10_valid", 32'(host.rsp_valid), 32'd0);
      chk("lat_c10_busy",  32'(busy),           32'd0);

      // Three back-to-back requests
      t0 = cyc;
      host.req_valid = 1'b1;
      host.req_a     = rep(FP16_ONE);
      host.req_b     = rep(16'h4000);
      host.req_tag   = 4'd5;
      step();
      host.req_tag = 4'd6;
      chk("b2b_ready_2nd", 32'(host.req_ready), 32'd1);
      step();
      host.req_tag = 4'd7;
      chk("b2b_ready_3rd", 32'(host.req_ready), 32'd1);
      step();
      host.req_valid = 1'b0;
      chk("b2b_full_ready", 32'(host.req_ready), 32'd0);
      nrsp = 0; low_run = 0; min_gap = 1000; seen_high = 1'b0;
      for (int k = 0; k < 60 && nrsp < 3; k++) begin
         if (dot_start) begin
            if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
            low_run   = 0;
            seen_high = 1'b1;
         end else begin
            low_run++;
         end
         if (host.rsp_valid) begin
            d[nrsp]  = host.rsp_data;
            tg[nrsp] = host.rsp_tag;
            rc[nrsp] = cyc - t0;
            nrsp++;
         end
         step();
      end
      chk("b2b_count", 32'(nrsp), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b_data%0d", i),  32'(d[i]),  32'h5000);
         chk($sformatf("b2b_tag%0d", i),   32'(tg[i]), 32'(5 + i));
         chk($sformatf("b2b_cycle%0d", i), 32'(rc[i]), 32'(9 + 9 * i));
      end
      chk("b2b_min_start_gap", 32'(min_gap), 32'd2);

      // Overflow and saturating counter
      run_op(rep(FP16_MAX), rep(FP16_MAX), 4'd9);
      chk("ovf_flag",  32'(r_ovf),     32'd1);
      chk("ovf_data",  32'(r_data),    32'h7c00);
      chk("ovf_tag",   32'(r_tag),     32'd9);
      chk("ovf_cnt_1", 32'(ovf_count), 32'd1);
      run_op(rep(FP16_ONE), rep(FP16_ONE), 4'd1);
      chk("ovf_clean_flag", 32'(r_ovf),     32'd0);
      chk("ovf_cnt_hold",   32'(ovf_count), 32'd1);
      for (int i = 0; i < 254; i++) run_op(rep(FP16_MAX), rep(FP16_MAX), 4'(i));
      chk("ovf_cnt_255", 32'(ovf_count), 32'hff);
      run_op(rep(FP16_MAX), rep(FP16_MAX), 4'd0);
      chk("ovf_cnt_sat", 32'(ovf_count), 32'hff);

      // Watchdog: the unit never finishes
      stub_hang = 1'b1;
      push_req(rep(FP16_ONE), rep(FP16_ONE), 4'd2);
      hi = 0;
      for (int k = 0; k < 40 && !host.rsp_valid; k++) begin
         if (dot_start) hi++;
         step();
      end
      chk("to_valid",      32'(host.rsp_valid),   32'd1);
      chk("to_start_high", 32'(hi),               32'(TIMEOUT));
      chk("to_flag",       32'(host.rsp_timeout), 32'd1);
      chk("to_data",       32'(host.rsp_data),    32'd0);
      chk("to_ovf",        32'(host.rsp_ovf),     32'd0);
      chk("to_tag",        32'(host.rsp_tag),     32'd2);
      step();
      stub_hang = 1'b0;
      run_op(rep(FP16_ONE), rep(16'h4000), 4'd4);
      chk("after_to_data", 32'(r_data), 32'h5000);
      chk("after_to_flag", 32'(r_to),   32'd0);
      chk("after_to_tag",  32'(r_tag),  32'd4);

      // Response backpressure
      host.rsp_ready = 1'b0;
      push_req(rep(FP16_ONE), rep(16'h4000), 4'd1);
      wait_rsp("bp", 40);
      stable = 1'b1;
      pushes = 0;
      host.req_valid = 1'b1;
      host.req_tag   = 4'd2;
      for (int k = 0; k < 20; k++) begin
         if (host.req_valid && host.req_ready) pushes++;
         stable &= host.rsp_valid && (host.rsp_data == 16'h5000) && !host.rsp_ovf
                   && (host.rsp_tag == 4'd1) && !dot_start;
         step();
         if (pushes == 1) host.req_tag = 4'd3;
         if (pushes >= 2) host.req_valid = 1'b0;
      end
      chk("bp_stable",    32'(stable),         32'd1);
      chk("bp_pushes",    32'(pushes),         32'd2);
      chk("bp_req_ready", 32'(host.req_ready), 32'd0);
      chk("bp_dot_start", 32'(dot_start),      32'd0);
      host.rsp_ready = 1'b1;
      nrsp = 0;
      for (int k = 0; k < 60 && nrsp < 3; k++) begin
         if (host.rsp_valid) begin
            tg[nrsp] = host.rsp_tag;
            nrsp++;
         end
         step();
      end
      chk("bp_drain_count", 32'(nrsp), 32'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("bp_drain_tag%0d", i), 32'(tg[i]), 32'(1 + i));

      // Reset during RUN with a second request still buffered
      host.req_valid = 1'b1;
      host.req_a     = rep(FP16_ONE);
      host.req_b     = rep(FP16_ONE);
      host.req_tag   = 4'd6;
      step();
      host.req_tag = 4'd7;
      step();
      host.req_valid = 1'b0;
      repeat (3) step();
      chk("mid_c5_start", 32'(dot_start), 32'd1);
      chk("mid_c5_busy",  32'(busy),      32'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_start",     32'(dot_start),        32'd0);
      chk("mid_rst_busy",      32'(busy),             32'd0);
      chk("mid_rst_req_ready", 32'(host.req_ready),   32'd1);
      chk("mid_rst_rsp_valid", 32'(host.rsp_valid),   32'd0);
      chk("mid_rst_rsp_tag",   32'(host.rsp_tag),     32'd0);
      chk("mid_rst_ovf_count", 32'(ovf_count),        32'd0);
      rst = 1'b0;
      saw_rsp = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         saw_rsp |= host.rsp_valid | dot_start;
      end
      chk("mid_rst_no_activity", 32'(saw_rsp), 32'd0);
      chk("mid_rst_idle_busy",   32'(busy),    32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
